// File: rtl/alu_hilo_if.sv
// Handshake/operand bus between the execute-stage controller and alu_hilo.
// The controller drives the request side and the ALU drives the response side.
interface alu_hilo_if #(
  parameter int n = 32
);
  logic         i_valid_in;
  logic [2:0]   i_alucontrol;
  logic [n-1:0] i_a;
  logic [n-1:0] i_b;
  logic         o_ready;
  logic         o_valid_out;
  logic [n-1:0] o_result;
  logic         o_zero;
  logic [n-1:0] o_hi;
  logic [n-1:0] o_lo;

  modport master (
    output i_valid_in, i_alucontrol, i_a, i_b,
    input  o_ready, o_valid_out, o_result, o_zero, o_hi, o_lo
  );

  modport slave (
    input  i_valid_in, i_alucontrol, i_a, i_b,
    output o_ready, o_valid_out, o_result, o_zero, o_hi, o_lo
  );
endinterface

// File: rtl/alu_hilo.sv
// Execute-stage ALU with single-cycle ops and an iterative signed multiplier into HI/LO.
// Optional macro ALU_HILO_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module alu_hilo #(
  parameter int n = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_hilo_if.slave bus
);

  localparam int CW = $clog2(n + 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_MFLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [n-1:0]   ZERO_N   = {n{1'b0}};
  localparam logic [n-1:0]   ONE_N    = {{(n-1){1'b0}}, 1'b1};
  localparam logic [2*n-1:0] ZERO_2N  = {(2*n){1'b0}};
  localparam logic [2*n-1:0] ONE_2N   = {{(2*n-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The most-negative value maps to 2^(n-1) as an unsigned n-bit magnitude.
  function automatic logic [n-1:0] f_abs(input logic [n-1:0] v);
    f_abs = v[n-1] ? (~v + ONE_N) : v;
  endfunction

  function automatic logic [2*n-1:0] f_neg2(input logic [2*n-1:0] v);
    f_neg2 = ~v + ONE_2N;
  endfunction

  state_t         r_state;
  logic           r_ready;
  logic           r_valid;
  logic [n-1:0]   r_result;
  logic           r_zero;
  logic [n-1:0]   r_hi;
  logic [n-1:0]   r_lo;
  logic [2*n-1:0] r_acc;
  logic [2*n-1:0] r_mcand;
  logic [n-1:0]   r_mplier;
  logic           r_sign;
  logic [CW-1:0]  r_cnt;

  logic [n-1:0]   w_alu;
  logic [2*n-1:0] w_acc_step;
  logic [2*n-1:0] w_prod;
  logic           w_last;
  logic           w_accept;

  assign w_accept = bus.i_valid_in && r_ready;

  // Result of the single-cycle ops and HI/LO reads for the current request.
  always_comb begin
    w_alu = ZERO_N;
    case (bus.i_alucontrol)
      OP_AND:  w_alu = bus.i_a & bus.i_b;
      OP_OR:   w_alu = bus.i_a | bus.i_b;
      OP_ADD:  w_alu = bus.i_a + bus.i_b;
      OP_SUB:  w_alu = bus.i_a - bus.i_b;
      OP_SLT:  w_alu = ($signed(bus.i_a) < $signed(bus.i_b)) ? ONE_N : ZERO_N;
      OP_MFLO: w_alu = r_lo;
      OP_MFHI: w_alu = r_hi;
      OP_MULT: w_alu = ZERO_N;
      default: w_alu = ZERO_N;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_step = r_acc;
    if (r_mplier[0]) begin
      w_acc_step = r_acc + r_mcand;
    end else begin
      w_acc_step = r_acc;
    end
  end

  // Signed product as it will land in {hi,lo} once the last step is taken.
  always_comb begin
    w_prod = w_acc_step;
    if (r_sign) begin
      w_prod = f_neg2(w_acc_step);
    end else begin
      w_prod = w_acc_step;
    end
  end

`ifdef ALU_HILO_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_LAST) || (r_mplier[n-1:1] == {(n-1){1'b0}});
`else
  assign w_last = (r_cnt == CNT_LAST);
`endif

  // Control FSM, multiplier datapath and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_result <= ZERO_N;
      r_zero   <= 1'b1;
      r_hi     <= ZERO_N;
      r_lo     <= ZERO_N;
      r_acc    <= ZERO_2N;
      r_mcand  <= ZERO_2N;
      r_mplier <= ZERO_N;
      r_sign   <= 1'b0;
      r_cnt    <= CNT_ZERO;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (bus.i_alucontrol == OP_MULT)) begin
            r_mcand  <= {ZERO_N, f_abs(bus.i_a)};
            r_mplier <= f_abs(bus.i_b);
            r_sign   <= bus.i_a[n-1] ^ bus.i_b[n-1];
            r_acc    <= ZERO_2N;
            r_cnt    <= CNT_ZERO;
            r_ready  <= 1'b0;
            r_state  <= S_MUL;
          end else if (w_accept) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == ZERO_N);
            r_valid  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_step;
          r_mcand  <= {r_mcand[2*n-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[n-1:1]};
          r_cnt    <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_hi     <= w_prod[2*n-1:n];
            r_lo     <= w_prod[n-1:0];
            r_result <= w_prod[n-1:0];
            r_zero   <= (w_prod[n-1:0] == ZERO_N);
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state  <= S_MUL;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready     = r_ready;
  assign bus.o_valid_out = r_valid;
  assign bus.o_result    = r_result;
  assign bus.o_zero      = r_zero;
  assign bus.o_hi        = r_hi;
  assign bus.o_lo        = r_lo;

endmodule

// File: doc/alu_hilo.md
Name: alu_hilo

Overview:
- Execution-side counterpart of the ALU decoder. Consumes the 3-bit alucontrol code and two operands, and produces the datapath result.
- Single-cycle ops: add, sub, and, or, slt.
- mult: iterative signed multiplier writing internal HI/LO registers.
- mfhi/mflo: read HI/LO back.
- Sits in the execute stage; a valid/ready handshake lets the controller stall while a multiply is in flight.

Parameters:
- n, 32, operand/result width in bits; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- valid_in  input  1  operation request; accepted on a clock edge where valid_in && ready
- alucontrol  input  3  op code: 000 and, 001 or, 010 add, 110 sub, 111 slt, 011 mult, 100 mflo, 101 mfhi
- a  input  n  operand A (rs)
- b  input  n  operand B (rt or immediate)
- ready  output  1  block can accept an operation this cycle
- valid_out  output  1  one-cycle pulse: result/zero are valid
- result  output  n  registered operation result
- zero  output  1  registered (result == 0)
- hi  output  n  HI register
- lo  output  n  LO register

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; ready=1, valid_out=0, result=0, zero=1, hi=0, lo=0; iteration counter and partial product cleared. A multiply in flight is aborted and HI/LO are left at 0.
- FSM states: IDLE, MUL, DONE.
- IDLE, accept of a non-mult op: result/zero are registered at the edge. valid_out=1 in the next cycle (latency 1). State stays IDLE and ready stays 1, so back-to-back issue is allowed.
- add/sub: modulo 2^n, no overflow flag.
- and/or: bitwise.
- slt: result=1 if $signed(a) < $signed(b), else 0.
- mflo: result=lo. mfhi: result=hi.
- Reserved code: none; all 8 codes are defined. An X/unknown code produces result=0 and valid_out=1.
- IDLE, accept of mult (011):
  - Latch |a|, |b| and sign = a[n-1]^b[n-1].
  - Clear the 2n-bit accumulator and counter; go to MUL; ready=0.
- MUL: radix-2 shift-add, one multiplier bit per cycle. After n MUL cycles, go to DONE.
- DONE (1 cycle):
  - {hi,lo} = sign ? -acc : acc (2n-bit two's complement).
  - result=lo; valid_out=1 in this cycle.
  - Return to IDLE; ready=1 again in the following cycle.
- Multiply latency: accept edge -> valid_out is n+1 cycles (33 for n=32).
- ready=0 throughout MUL and DONE. valid_in is ignored while ready=0, and the requester must hold its op.
  - This guarantees mfhi/mflo never observe a partial product.
- HI/LO change only in DONE. All other ops leave them untouched.
- Operand edge cases:
  - a or b = most-negative value: the magnitude is treated as an n-bit unsigned 2^(n-1), and the product must be exact. Example: -2^31 * -2^31 = 2^62.
- valid_out and ready are never both asserted in DONE.

Optional Feature:
- Macro: ALU_HILO_EARLY_TERM_EN.
- Defined: in MUL, if the remaining unshifted multiplier bits are all zero, go to DONE on the next edge. Latency becomes (index of highest set bit of |b|)+2 cycles, with a minimum of 2 (b==0). Product values are unchanged.
- Undefined: fixed n MUL cycles as above.

Test Plan:
- Reset, then single-cycle ops:
  - add 7+5 -> result=12, zero=0
  - sub 5-5 -> result=0, zero=1
  - and 0xF0F0&0xFF00 -> 0xF000
  - or -> 0xFFF0
  - valid_out 1 cycle after each accept, ready held 1.
- slt: a=0xFFFFFFFF, b=1 -> result=1; a=1, b=0xFFFFFFFF -> result=0.
- mult -3 * 7:
  - ready=0 for 33 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=0xFFFFFFEB.
  - Follow-on mfhi -> 0xFFFFFFFF, mflo -> 0xFFFFFFEB.
- mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- mfhi issued (valid_in held) 1 cycle after mult accept: ignored until ready=1, then returns the final hi. add issued mid-multiply: not accepted, and hi/lo are unaffected.
- Reset pulsed at MUL cycle 10 of 0x1234*0x10: next cycle ready=1, hi=lo=0, valid_out=0. With ALU_HILO_EARLY_TERM_EN, a subsequent mult 9*0x10 completes in 6 cycles with lo=0x90.
